// File: rtl/hb_cipher_round_ctrl.sv
// Iterative Hummingbird-style 16-bit block-cipher round controller: one key-mix/S-box/L step per clock.
// Optional HB_ZEROIZE_EN clears state and round keys on output handshake and gates dout to 0 when idle.
module hb_cipher_round_ctrl #(
   parameter int ROUNDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mode,
   input  logic [15:0] din,
   input  logic [63:0] key,
   output logic [15:0] sb_x,
   output logic        sb_inv,
   input  logic [15:0] sb_y,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] dout,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [3:0] LAST = 4'(ROUNDS);

   state_t           state_q;
   logic [3:0]       cnt_q;
   logic             mode_q;
   logic [15:0]      x_q, x_d;
   logic [3:0][15:0] k_q;
   logic             out_valid_q, busy_q;
   logic [15:0]      rka, rkb;

   function automatic logic [15:0] rotl(input logic [15:0] m, input int r);
      return (m << r) | (m >> (16 - r));
   endfunction

   function automatic logic [15:0] l_enc(input logic [15:0] m);
      return m ^ rotl(m, 6) ^ rotl(m, 10);
   endfunction

   function automatic logic [15:0] l_dec(input logic [15:0] m);
      return m ^ rotl(m, 2) ^ rotl(m, 4) ^ rotl(m, 12) ^ rotl(m, 14);
   endfunction

   assign rka = k_q[0] ^ k_q[2];
   assign rkb = k_q[1] ^ k_q[3];

   // Decrypt walks the round keys backwards: step cnt undoes round ROUNDS-cnt.
   always_comb begin
      sb_x   = '0;
      sb_inv = 1'b0;
      x_d    = x_q;
      if (state_q == S_RUN) begin
         if (!mode_q) begin
            if (cnt_q < LAST) begin
               sb_x = x_q ^ k_q[cnt_q[1:0]];
               x_d  = l_enc(sb_y);
            end else begin
               sb_x = x_q ^ rka;
               x_d  = sb_y ^ rkb;
            end
         end else begin
            sb_inv = 1'b1;
            if (cnt_q == 4'd0) begin
               sb_x = x_q ^ rkb;
               x_d  = sb_y ^ rka;
            end else begin
               sb_x = l_dec(x_q);
               x_d  = sb_y ^ k_q[2'(LAST - cnt_q)];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         x_q         <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  x_q     <= din;
                  k_q     <= key;
                  mode_q  <= mode;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               x_q   <= x_d;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == LAST) begin
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
`ifdef HB_ZEROIZE_EN
                  x_q <= '0;
                  k_q <= '0;
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // in_ready must already read 0 during the reset cycle itself.
   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

`ifdef HB_ZEROIZE_EN
   assign dout = out_valid_q ? x_q : 16'h0000;
`else
   assign dout = x_q;
`endif

endmodule

// File: tb/tb_hb_cipher_round_ctrl.sv
// Bench: ROUNDS=1 engine with identity S-box and ROUNDS=4 engine with a nibble S-box,
// both checked every cycle against a transaction-level cipher model.
module tb_hb_cipher_round_ctrl;

   logic        clk;
   logic        rst       [2];
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic        mode      [2];
   logic [15:0] din       [2];
   logic [63:0] key       [2];
   logic [15:0] sb_x      [2];
   logic        sb_inv    [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [15:0] dout      [2];
   logic        busy      [2];
   logic [15:0] sby0, sby1;

   int total = 0;
   int bad   = 0;

`ifdef HB_ZEROIZE_EN
   localparam bit ZERO = 1'b1;
`else
   localparam bit ZERO = 1'b0;
`endif

   localparam logic [63:0] KREF = 64'h0123_4567_89AB_CDEF;

   logic [3:0] SB [16] = '{4'h8, 4'h6, 4'h5, 4'hF, 4'h1, 4'hC, 4'hA, 4'h9,
                           4'hE, 4'hB, 4'h2, 4'h4, 4'h7, 4'h0, 4'hD, 4'h3};

   function automatic int rnd(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic logic [15:0] rl(input logic [15:0] m, input int r);
      return (m << r) | (m >> (16 - r));
   endfunction

   function automatic logic [15:0] lenc(input logic [15:0] m);
      return m ^ rl(m, 6) ^ rl(m, 10);
   endfunction

   function automatic logic [15:0] ldec(input logic [15:0] m);
      return m ^ rl(m, 2) ^ rl(m, 4) ^ rl(m, 12) ^ rl(m, 14);
   endfunction

   function automatic logic [15:0] sbox(input logic [15:0] v, input bit inv, input bit ident);
      logic [15:0] r;
      logic [3:0]  n;
      if (ident) return v;
      r = '0;
      for (int b = 0; b < 4; b++) begin
         n = v[4*b +: 4];
         if (!inv) r[4*b +: 4] = SB[n];
         else
            for (int k = 0; k < 16; k++)
               if (SB[k] == n) r[4*b +: 4] = 4'(k);
      end
      return r;
   endfunction

   function automatic logic [15:0] kw(input logic [63:0] k, input int r);
      return k[16*(r % 4) +: 16];
   endfunction

   function automatic logic [15:0] enc_ref(input logic [15:0] p, input logic [63:0] k,
                                           input int nr, input bit ident);
      logic [15:0] x;
      x = p;
      for (int r = 0; r < nr; r++) x = lenc(sbox(x ^ kw(k, r), 0, ident));
      return sbox(x ^ kw(k, 0) ^ kw(k, 2), 0, ident) ^ kw(k, 1) ^ kw(k, 3);
   endfunction

   function automatic logic [15:0] dec_ref(input logic [15:0] c, input logic [63:0] k,
                                           input int nr, input bit ident);
      logic [15:0] x;
      x = sbox(c ^ kw(k, 1) ^ kw(k, 3), 1, ident) ^ kw(k, 0) ^ kw(k, 2);
      for (int r = nr - 1; r >= 0; r--) x = sbox(ldec(x), 1, ident) ^ kw(k, r);
      return x;
   endfunction

   assign sby0 = sb_x[0];
   always_comb sby1 = sbox(sb_x[1], sb_inv[1], 1'b0);

   hb_cipher_round_ctrl #(.ROUNDS(1)) u_a (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .mode(mode[0]), .din(din[0]), .key(key[0]), .sb_x(sb_x[0]), .sb_inv(sb_inv[0]),
      .sb_y(sby0), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .dout(dout[0]),
      .busy(busy[0]));

   hb_cipher_round_ctrl #(.ROUNDS(4)) u_b (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .mode(mode[1]), .din(din[1]), .key(key[1]), .sb_x(sb_x[1]), .sb_inv(sb_inv[1]),
      .sb_y(sby1), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .dout(dout[1]),
      .busy(busy[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] t=%0t got=%h expected=%h", nm, i, $time, act, exp);
      end
   endtask

   // Transaction model: accept when idle, result due ROUNDS+1 edges later, hold until out_ready.
   bit          m_busy [2] = '{0, 0};
   int          m_left [2] = '{0, 0};
   bit          m_mode [2] = '{0, 0};
   logic [15:0] m_res  [2] = '{16'h0, 16'h0};
   logic [15:0] m_last [2] = '{16'h0, 16'h0};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            m_busy[i] <= 1'b0;
            m_left[i] <= 0;
            m_last[i] <= '0;
         end else if (!m_busy[i]) begin
            if (in_valid[i]) begin
               m_busy[i] <= 1'b1;
               m_left[i] <= rnd(i) + 1;
               m_mode[i] <= mode[i];
               m_res[i]  <= mode[i] ? dec_ref(din[i], key[i], rnd(i), i == 0)
                                    : enc_ref(din[i], key[i], rnd(i), i == 0);
            end
         end else if (m_left[i] != 0) begin
            m_left[i] <= m_left[i] - 1;
         end else if (out_ready[i]) begin
            m_busy[i] <= 1'b0;
            m_last[i] <= ZERO ? 16'h0 : m_res[i];
         end
      end
   end

   bit run, done;
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         run  = m_busy[i] && (m_left[i] != 0);
         done = m_busy[i] && (m_left[i] == 0);
         chk("in_ready", i, 32'(in_ready[i]), 32'(!m_busy[i] && !rst[i]));
         chk("out_valid", i, 32'(out_valid[i]), 32'(done));
         chk("busy", i, 32'(busy[i]), 32'(m_busy[i]));
         chk("sb_inv", i, 32'(sb_inv[i]), 32'(run ? m_mode[i] : 1'b0));
         if (!run) chk("sb_x_idle", i, 32'(sb_x[i]), 32'h0);
         if (done) chk("dout", i, 32'(dout[i]), 32'(m_res[i]));
         else if (!m_busy[i]) chk("dout_idle", i, 32'(dout[i]), 32'(m_last[i]));
         else if (ZERO) chk("dout_run", i, 32'(dout[i]), 32'h0);
      end
   end

   task automatic run_op(input int i, input bit md, input logic [15:0] d, input logic [63:0] k,
                         input int hold, input bit keep, output logic [15:0] res);
      int t;
      in_valid[i] = 1'b1; mode[i] = md; din[i] = d; key[i] = k;
      t = 0;
      do begin @(posedge clk); #1; t++; end while (!m_busy[i] && t < 20);
      if (!m_busy[i]) begin bad++; $display("FAIL accept_timeout[%0d] got=idle expected=busy", i); end
      if (!keep) in_valid[i] = 1'b0;
      din[i] = 16'($urandom); key[i] = {$urandom, $urandom}; mode[i] = 1'($urandom);
      t = 0;
      while (m_left[i] != 0 && t < 40) begin @(posedge clk); #1; t++; end
      repeat (hold) begin @(posedge clk); #1; end
      res = dout[i];
      out_ready[i] = 1'b1;
      @(posedge clk); #1;
      out_ready[i] = 1'b0;
   endtask

   logic [15:0] p, c, q;
   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; in_valid[i] = 1'b0; mode[i] = 1'b0;
         din[i] = '0; key[i] = '0; out_ready[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Hand-computed pins for the model itself.
      chk("pin_lenc", 0, 32'(lenc(16'h0001)), 32'h0441);
      chk("pin_enc1", 0, 32'(enc_ref(16'h0001, 64'h0, 1, 1)), 32'h0441);
      chk("pin_dec1", 0, 32'(dec_ref(16'h0441, 64'h0, 1, 1)), 32'h0001);
      chk("pin_sbox", 1, 32'(sbox(16'h0123, 0, 0)), 32'h865F);
      chk("pin_sinv", 1, 32'(sbox(16'h865F, 1, 0)), 32'h0123);
      p = 16'($urandom);
      chk("pin_ldec", 1, 32'(ldec(lenc(p))), 32'(p));

      run_op(0, 1'b0, 16'h0001, 64'h0, 0, 1'b0, c);
      chk("a_enc", 0, 32'(c), 32'h0441);
      run_op(0, 1'b1, 16'h0441, 64'h0, 1, 1'b0, q);
      chk("a_dec", 0, 32'(q), 32'h0001);

      for (int n = 0; n < 64; n++) begin
         p = 16'($urandom);
         run_op(1, 1'b0, p, KREF, $urandom_range(0, 2), 1'b0, c);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         run_op(1, 1'b1, c, KREF, $urandom_range(0, 2), 1'b0, q);
         chk("b_roundtrip", 1, 32'(q), 32'(p));
      end

      // Random keys, a few more round trips.
      for (int n = 0; n < 6; n++) begin
         logic [63:0] kr;
         kr = {$urandom, $urandom};
         p = 16'($urandom);
         run_op(1, 1'b0, p, kr, 0, 1'b0, c);
         run_op(1, 1'b1, c, kr, 0, 1'b0, q);
         chk("b_rk_roundtrip", 1, 32'(q), 32'(p));
      end

      // Back-pressure with a requester that keeps in_valid high.
      p = 16'hBEEF;
      run_op(1, 1'b0, p, KREF, 10, 1'b1, c);
`ifdef HB_ZEROIZE_EN
      chk("x_zeroized", 1, 32'(u_b.x_q), 32'h0);
`else
      chk("dout_retained", 1, 32'(dout[1]), 32'(c));
`endif
      run_op(1, 1'b1, c, KREF, 0, 1'b0, q);
      chk("bp_roundtrip", 1, 32'(q), 32'(p));

      // Abort at cnt=2 via reset.
      in_valid[1] = 1'b1; mode[1] = 1'b0; din[1] = 16'h1234; key[1] = KREF;
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst[1] = 1'b1;
      @(posedge clk); #1;
      rst[1] = 1'b0;
      chk("abort_out_valid", 1, 32'(out_valid[1]), 32'h0);
      chk("abort_busy", 1, 32'(busy[1]), 32'h0);
      repeat (8) begin @(posedge clk); #1; end
      p = 16'h1234;
      run_op(1, 1'b0, p, KREF, 0, 1'b0, c);
      chk("post_abort_enc", 1, 32'(c), 32'(enc_ref(p, KREF, 4, 0)));
      run_op(1, 1'b1, c, KREF, 0, 1'b0, q);
      chk("post_abort_rt", 1, 32'(q), 32'(p));

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
